normalise_sequencer: RTL and testbench
======================================

// Module: normalise_sequencer
// PURPOSE
//  Frame-level controller for the normalising datapath (18-bit filter sum -> 8-bit pixel).
//  On a start pulse it walks pixel addresses START_ADDR..END_ADDR in ADDR_STEP increments.
//  Per pixel slot it issues a buffer read, then a normalise strobe, then the output-buffer write.
//  Sits between the gaussian buffer (read side), the normalising datapath and the output pixel buffer.
// PARAMETERS
//  START_ADDR  770     first pixel address processed (two rows/cols in from frame edge)
//  END_ADDR    523518  last pixel address processed (inclusive)
//  ADDR_STEP   2       address increment per slot (2 = two concurrent pixels per slot)
//  BEATS       4       active cycles per slot, >=1
//  PAUSE       1       idle cycles between slots, >=0
//  PIPE_LAT    1       normalise strobe -> result valid latency in cycles, >=1
//  ADDR_W      24      address width
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       asynchronous, active-high reset
//  start    in   1       1-cycle request to process one frame; ignored while busy=1
//  stall    in   1       downstream not ready; freezes slot sequencing
//  rd_en    out  1       read strobe to gaussian buffer, first beat of each slot
//  rd_addr  out  ADDR_W  pixel address for the current slot
//  norm_en  out  1       normalise strobe to datapath, last beat of each slot
//  wr_en    out  1       output-buffer write strobe = norm_en delayed PIPE_LAT cycles
//  wr_addr  out  ADDR_W  write address = rd_addr of the slot, delayed with wr_en
//  busy     out  1       high from the cycle after start is accepted until done
//  done     out  1       1-cycle pulse when the frame is complete
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all counters=0; delay line cleared.
//   Outputs on reset: rd_en=norm_en=wr_en=busy=done=0, rd_addr=wr_addr=START_ADDR.
//  FSM states: IDLE, RUN, GAP, DRAIN, DONE.
//  IDLE:  start=1 -> RUN next cycle, with beat=0 and rd_addr=START_ADDR.
//  RUN:   beat counts 0..BEATS-1. rd_en=1 at beat 0; norm_en=1 at beat BEATS-1.
//         BEATS=1: rd_en and norm_en are both high in the same cycle.
//         After beat BEATS-1, if rd_addr is the last slot -> DRAIN.
//         Otherwise, PAUSE>0 -> GAP; PAUSE=0 -> RUN with beat=0.
//  GAP:   lasts PAUSE cycles, all strobes low. On exit: rd_addr += ADDR_STEP, -> RUN, beat=0.
//  Addressing: with PAUSE=0 the increment happens on the RUN->RUN transition.
//  Last slot: rd_addr + ADDR_STEP > END_ADDR.
//   Compute in ADDR_W+1 bits; no wrap is permitted.
//   END_ADDR itself is processed if it lies on the step grid.
//  DRAIN: lasts PIPE_LAT cycles so the final wr_en is emitted; -> DONE.
//  DONE:  done=1 for one cycle, busy=0; -> IDLE. rd_addr returns to START_ADDR.
//  busy=1 in RUN, GAP and DRAIN.
//  Stall:
//   stall=1 in RUN or GAP: beat/gap counters and rd_addr hold; rd_en and norm_en forced 0.
//   The slot resumes on the same beat when stall drops.
//   stall is ignored in IDLE, DRAIN and DONE; the delay line always advances.
//  start during busy or DONE: ignored, no queueing.
//   start in the same cycle as reset: reset wins.
//  Delay line: a PIPE_LAT-deep shift register of {norm_en, rd_addr}.
//   Its output drives {wr_en, wr_addr}. It is independent of stall.
//  Elaboration check: START_ADDR <= END_ADDR, BEATS >= 1, PIPE_LAT >= 1; otherwise $error.
//  Slots per frame: (END_ADDR - START_ADDR) / ADDR_STEP + 1.
// STRUCTURE
//  Package norm_seq_pkg: state enum {IDLE,RUN,GAP,DRAIN,DONE}.
//   It also holds the default frame-bound constants and the normalising divisor constant 732.
//  Sub-module norm_slot_timer: beat/gap counter with freeze input.
//   It outputs first_beat, last_beat and slot_end.
//  Top-level: FSM, address register and delay line.
// TESTING
//  START=10, END=16, STEP=2, BEATS=4, PAUSE=1, PIPE_LAT=1; start at cycle 0:
//   rd_en at cycles 1,6,11,16; norm_en at 4,9,14,19 with addr 10,12,14,16.
//   wr_en at 5,10,15,20; done at cycle 21 only.
//  Same configuration with stall=1 for cycles 7-9:
//   norm_en for addr 12 moves to cycle 12; all later events shift by 3; done at cycle 24.
//  PAUSE=0, BEATS=1:
//   rd_en=norm_en continuous in cycles 1-4 for addr 10,12,14,16; done at cycle 6.
//  Reset asserted mid-frame at cycle 8 (async, between clock edges):
//   all outputs return to reset values immediately.
//   A later start restarts at addr 10.
//  start pulsed again at cycle 3 while busy: no effect; exactly 4 norm_en pulses and 1 done.
//  END not on the grid (END=15): last processed addr is 14; 3 slots; no addr above 15 is issued.

Source files
------------

// File: rtl/norm_seq_pkg.sv
// Shared definitions for the normalise sequencer.
// Contents:
//   state_t        frame controller states
//   DEF_*          default frame bounds and address geometry
//   NORM_DIVISOR   divisor applied by the normalising datapath (18-bit sum -> 8-bit pixel)
//   cnt_width()    bits needed for a counter that runs 0..max_val-1
package norm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_START_ADDR = 770;     // two rows/cols in from the frame edge
    localparam int DEF_END_ADDR   = 523518;  // last pixel address processed (inclusive)
    localparam int DEF_ADDR_STEP  = 2;       // two pixels handled per slot
    localparam int DEF_ADDR_W     = 24;
    localparam int NORM_DIVISOR   = 732;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/norm_slot_timer.sv
// Beat / gap counter for one pixel slot.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   active       controller is in RUN or GAP (counter cleared otherwise)
//   in_gap       1 = counting idle gap cycles, 0 = counting slot beats
//   freeze       hold the counter (downstream stall)
//   first_beat   beat 0 of a slot
//   last_beat    beat BEATS-1 of a slot
//   slot_end     current phase (beats or gap) completes this cycle
module norm_slot_timer
    import norm_seq_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int PAUSE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic in_gap,
    input  logic freeze,
    output logic first_beat,
    output logic last_beat,
    output logic slot_end
);

    localparam int MAXC = (BEATS > PAUSE) ? BEATS : PAUSE;
    localparam int CW   = cnt_width(MAXC);
    localparam logic [CW-1:0] BEAT_LAST = CW'(BEATS - 1);
    // PAUSE=0 never enters the gap phase, so its terminal value is irrelevant.
    localparam logic [CW-1:0] GAP_LAST  = CW'((PAUSE > 0) ? PAUSE - 1 : 0);

    logic [CW-1:0] cnt;
    logic          phase_last;

    assign phase_last = in_gap ? (cnt == GAP_LAST) : (cnt == BEAT_LAST);
    assign first_beat = active && !in_gap && (cnt == '0);
    assign last_beat  = active && !in_gap && (cnt == BEAT_LAST);
    assign slot_end   = active && phase_last && !freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (freeze) begin
            cnt <= cnt;
        end else if (phase_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/normalise_sequencer.sv
// Frame-level controller for the normalising datapath.
// Walks pixel addresses START_ADDR..END_ADDR in ADDR_STEP increments; per slot
// it issues a buffer read (first beat), a normalise strobe (last beat) and,
// PIPE_LAT cycles later, the output-buffer write.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             1-cycle frame request, ignored unless idle
//   stall             freezes slot sequencing in RUN/GAP
//   rd_en, rd_addr    gaussian buffer read strobe / current slot address
//   norm_en           normalise strobe to the datapath
//   wr_en, wr_addr    output buffer write strobe / address (norm_en, rd_addr delayed)
//   busy, done        frame in progress / 1-cycle completion pulse
module normalise_sequencer
    import norm_seq_pkg::*;
#(
    parameter int START_ADDR = DEF_START_ADDR,
    parameter int END_ADDR   = DEF_END_ADDR,
    parameter int ADDR_STEP  = DEF_ADDR_STEP,
    parameter int BEATS      = 4,
    parameter int PAUSE      = 1,
    parameter int PIPE_LAT   = 1,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              norm_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int AW1 = ADDR_W + 1;
    localparam int DW  = cnt_width(PIPE_LAT);
    localparam logic [DW-1:0]     DRAIN_LAST = DW'(PIPE_LAT - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);

    if (START_ADDR > END_ADDR || BEATS < 1 || PIPE_LAT < 1 || ADDR_STEP < 1) begin : g_bad_cfg
        $error("normalise_sequencer: illegal parameter set");
    end

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic            in_run;
    logic            in_gap;
    logic            first_beat;
    logic            last_beat;
    logic            slot_end;
    logic [AW1-1:0]  next_addr;
    logic            last_slot;

    assign in_run = (state == RUN);
    assign in_gap = (state == GAP);

    norm_slot_timer #(
        .BEATS (BEATS),
        .PAUSE (PAUSE)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .active     (in_run || in_gap),
        .in_gap     (in_gap),
        .freeze     (stall),
        .first_beat (first_beat),
        .last_beat  (last_beat),
        .slot_end   (slot_end)
    );

    // One extra bit so a step past the top of the address space is seen as
    // "beyond END_ADDR" instead of wrapping back into range.
    assign next_addr = {1'b0, rd_addr} + AW1'(ADDR_STEP);
    assign last_slot = next_addr > AW1'(END_ADDR);

    assign rd_en   = in_run && first_beat && !stall;
    assign norm_en = in_run && last_beat && !stall;
    assign busy    = in_run || in_gap || (state == DRAIN);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_addr   <= FIRST_ADDR;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        rd_addr <= FIRST_ADDR;
                    end
                end
                RUN: begin
                    if (slot_end) begin
                        if (last_slot) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else if (PAUSE > 0) begin
                            state <= GAP;
                        end else begin
                            // Back-to-back slots: advance address on RUN->RUN.
                            rd_addr <= next_addr[ADDR_W-1:0];
                        end
                    end
                end
                GAP: begin
                    if (slot_end) begin
                        state   <= RUN;
                        rd_addr <= next_addr[ADDR_W-1:0];
                    end
                end
                DRAIN: begin
                    // Not stall-gated: the final write must still emerge.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    rd_addr <= FIRST_ADDR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-side delay line of {norm_en, rd_addr}; always advances.
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : stage
        logic              en_q;
        logic [ADDR_W-1:0] addr_q;
        logic              en_in;
        logic [ADDR_W-1:0] addr_in;

        if (gi == 0) begin : g_head
            assign en_in   = norm_en;
            assign addr_in = rd_addr;
        end else begin : g_tail
            assign en_in   = stage[gi-1].en_q;
            assign addr_in = stage[gi-1].addr_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                en_q   <= 1'b0;
                addr_q <= FIRST_ADDR;
            end else begin
                en_q   <= en_in;
                addr_q <= addr_in;
            end
        end
    end

    assign wr_en   = stage[PIPE_LAT-1].en_q;
    assign wr_addr = stage[PIPE_LAT-1].addr_q;

endmodule

// File: tb/tb_normalise_sequencer.sv
// Scoreboard bench for normalise_sequencer over three parameter sets.
// Each frame's expected rd/norm/wr/done events (cycle + address) are derived
// from a flat list of slot work units and a pre-drawn random stall pattern,
// pushed into a queue, and consumed by an independent per-cycle monitor.
module tb_normalise_sequencer;

    typedef struct {
        int kind;   // 0 rd, 1 norm, 2 wr, 3 done
        int cyc;
        int addr;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int fin_cnt  = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", nm, act, req, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int C_START = (gi == 2) ? 5 : 10;
        localparam int C_END   = (gi == 0) ? 16 : (gi == 1) ? 15 : 20;
        localparam int C_STEP  = (gi == 2) ? 3 : 2;
        localparam int C_BEATS = (gi == 0) ? 4 : (gi == 1) ? 1 : 3;
        localparam int C_PAUSE = (gi == 0) ? 1 : (gi == 1) ? 0 : 2;
        localparam int C_PIPE  = (gi == 0) ? 1 : (gi == 1) ? 2 : 3;
        localparam int MAXR    = 511;

        logic        reset;
        logic        start;
        logic        stall;
        logic        rd_en;
        logic        norm_en;
        logic        wr_en;
        logic        busy;
        logic        done;
        logic [15:0] rd_addr;
        logic [15:0] wr_addr;

        ev_t exp_q[$];
        int  busy_lo = 1;
        int  busy_hi = 0;

        normalise_sequencer #(
            .START_ADDR (C_START),
            .END_ADDR   (C_END),
            .ADDR_STEP  (C_STEP),
            .BEATS      (C_BEATS),
            .PAUSE      (C_PAUSE),
            .PIPE_LAT   (C_PIPE),
            .ADDR_W     (16)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .start   (start),
            .stall   (stall),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .norm_en (norm_en),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .busy    (busy),
            .done    (done)
        );

        task automatic chk_reset_outputs(input string tag);
            chk($sformatf("cfg%0d %s rd_en", gi, tag), rd_en, 0);
            chk($sformatf("cfg%0d %s norm_en", gi, tag), norm_en, 0);
            chk($sformatf("cfg%0d %s wr_en", gi, tag), wr_en, 0);
            chk($sformatf("cfg%0d %s busy", gi, tag), busy, 0);
            chk($sformatf("cfg%0d %s done", gi, tag), done, 0);
            chk($sformatf("cfg%0d %s rd_addr", gi, tag), rd_addr, C_START);
            chk($sformatf("cfg%0d %s wr_addr", gi, tag), wr_addr, C_START);
        endtask

        // Called just after a rising edge; returns just after a rising edge.
        task automatic run_frame(input int pct, input bit poke, input int rst_rel);
            bit stl [0:MAXR];
            int u_beat[$];
            int u_addr[$];
            int s, c, p, n, done_c, rel;
            s = cyc;
            n = (C_END - C_START) / C_STEP + 1;
            for (int k = 0; k < n; k++) begin
                for (int b = 0; b < C_BEATS; b++) begin
                    u_beat.push_back(b);
                    u_addr.push_back(C_START + k * C_STEP);
                end
                if (k < n - 1) begin
                    for (int g = 0; g < C_PAUSE; g++) begin
                        u_beat.push_back(-1);
                        u_addr.push_back(0);
                    end
                end
            end
            foreach (stl[i]) stl[i] = ($urandom_range(99) < pct);
            // Every non-stalled cycle after start consumes one work unit.
            c = s + 1;
            p = 0;
            while (p < u_beat.size()) begin
                if (c - s <= MAXR && stl[c - s]) begin
                    c++;
                end else begin
                    if (u_beat[p] == 0)
                        exp_q.push_back('{kind: 0, cyc: c, addr: u_addr[p]});
                    if (u_beat[p] == C_BEATS - 1) begin
                        exp_q.push_back('{kind: 1, cyc: c, addr: u_addr[p]});
                        exp_q.push_back('{kind: 2, cyc: c + C_PIPE, addr: u_addr[p]});
                    end
                    p++;
                    c++;
                end
            end
            done_c = c + C_PIPE;
            exp_q.push_back('{kind: 3, cyc: done_c, addr: 0});
            busy_lo = s + 1;
            busy_hi = done_c - 1;
            $display("cfg%0d frame: start cycle %0d, %0d slots, stall %0d%%, done expected cycle %0d",
                     gi, s, n, pct, done_c);
            start = 1'b1;
            stall = stl[0];
            for (int i = 1; i <= done_c - s + 3; i++) begin
                @(posedge clk);
                #1;
                rel = cyc - s;
                if (rst_rel != 0 && rel == rst_rel) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    chk_reset_outputs("midframe_reset");
                    exp_q.delete();
                    busy_lo = 1;
                    busy_hi = 0;
                    start = 1'b1;   // coincident with reset: must be ignored
                    stall = 1'b0;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    return;
                end
                start = poke && (rel == 3 || rel == done_c - s);
                stall = (rel <= MAXR) ? stl[rel] : 1'b0;
            end
            start = 1'b0;
            stall = 1'b0;
        endtask

        always @(negedge clk) begin
            if (!reset) begin
                chk($sformatf("cfg%0d busy", gi), busy, (cyc >= busy_lo && cyc <= busy_hi));
                for (int k = 0; k < 4; k++) begin
                    int    idx;
                    bit    hit;
                    bit    act;
                    int    act_addr;
                    string nm;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].kind == k) begin
                            idx = i;
                            break;
                        end
                    end
                    hit = 1'b0;
                    if (idx >= 0) hit = (exp_q[idx].cyc == cyc);
                    case (k)
                        0:       begin act = rd_en;   act_addr = int'(rd_addr); nm = "rd_en";   end
                        1:       begin act = norm_en; act_addr = int'(rd_addr); nm = "norm_en"; end
                        2:       begin act = wr_en;   act_addr = int'(wr_addr); nm = "wr_en";   end
                        default: begin act = done;    act_addr = 0;             nm = "done";    end
                    endcase
                    chk($sformatf("cfg%0d %s", gi, nm), act, hit);
                    if (hit) begin
                        if (k != 3)
                            chk($sformatf("cfg%0d %s addr", gi, nm), act_addr, exp_q[idx].addr);
                        exp_q.delete(idx);
                    end
                end
            end
        end

        initial begin : drv
            int idle;
            reset = 1'b1;
            start = 1'b0;
            stall = 1'b0;
            @(posedge clk);
            #1;
            chk_reset_outputs("reset_state");
            @(posedge clk);
            #1;
            reset = 1'b0;
            for (int f = 0; f < 6; f++) begin
                idle = int'($urandom_range(3));
                repeat (idle) begin
                    @(posedge clk);
                    #1;
                end
                case (f)
                    0:       run_frame(0, 1'b0, 0);
                    1:       run_frame(0, 1'b1, 0);
                    2:       run_frame(25, 1'b0, 4);
                    3:       run_frame(30, 1'b1, 0);
                    4:       run_frame(40, 1'b0, 0);
                    default: run_frame(15, 1'b1, 0);
                endcase
            end
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("cfg%0d pending_events", gi), exp_q.size(), 0);
            fin_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 60000 && fin_cnt < 3; t++) @(posedge clk);
        chk("configs_finished", fin_cnt, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
